// File: rtl/mawg_multi_pkg.sv
// Shared types and field layout for the multi-channel waveform generator.
// A control entry is packed as {rep, length, offset}, offset in the LSBs.
package mawg_multi_pkg;

    localparam int NCH_DEF        = 2;
    localparam int CTRL_DEPTH_DEF = 2;
    localparam int WAVE_DEPTH_DEF = 9;
    localparam int WAVE_WIDTH_DEF = 16;
    localparam int REP_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int entry_w(input int rw, input int wd);
        return rw + 2 * wd + 1;
    endfunction

    function automatic int len_lsb(input int wd);
        return wd;
    endfunction

    function automatic int rep_lsb(input int wd);
        return 2 * wd + 1;
    endfunction

endpackage

// File: rtl/mawg_channel.sv
// One waveform channel: control table, wave RAM, sequencer FSM and
// the registered output stage behind the 1-cycle RAM read.
module mawg_channel
    import mawg_multi_pkg::*;
#(
    parameter int CTRL_DEPTH = CTRL_DEPTH_DEF,
    parameter int WAVE_DEPTH = WAVE_DEPTH_DEF,
    parameter int WAVE_WIDTH = WAVE_WIDTH_DEF,
    parameter int REP_W      = REP_W_DEF,
    localparam int EW        = entry_w(REP_W, WAVE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_we_i,
    input  logic [CTRL_DEPTH-1:0] ctrl_addr_i,
    input  logic [EW-1:0]         ctrl_data_i,
    input  logic                  wave_we_i,
    input  logic [WAVE_DEPTH-1:0] wave_addr_i,
    input  logic [WAVE_WIDTH-1:0] wave_data_i,
    input  logic                  kick_i,
    input  logic                  stop_i,
    input  logic [REP_W-1:0]      rep_i,
    input  logic [CTRL_DEPTH-1:0] last_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [WAVE_WIDTH-1:0] data_o
);

    localparam int LW      = WAVE_DEPTH + 1;
    localparam int LEN_LSB = len_lsb(WAVE_DEPTH);
    localparam int REP_LSB = rep_lsb(WAVE_DEPTH);

    logic [EW-1:0]         ctab [2**CTRL_DEPTH];
    logic [WAVE_WIDTH-1:0] wram [2**WAVE_DEPTH];
    logic [WAVE_WIDTH-1:0] rdata_q;

    state_e                state_q, state_d;
    logic [CTRL_DEPTH-1:0] idx_q, idx_d;
    logic [CTRL_DEPTH-1:0] last_q, last_d;
    logic [REP_W-1:0]      seq_q, seq_d;
    logic                  inf_q, inf_d;
    logic [WAVE_DEPTH-1:0] off_q, off_d;
    logic [LW-1:0]         len_q, len_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [REP_W-1:0]      rcnt_q, rcnt_d;
    logic                  rd_v_q, rd_v_d;
    logic                  val_q;
    logic [WAVE_WIDTH-1:0] data_q;

    logic [EW-1:0]         entry;
    logic [WAVE_DEPTH-1:0] e_off;
    logic [LW-1:0]         e_len;
    logic [REP_W-1:0]      e_rep;
    logic [REP_W-1:0]      rep_last;
    logic [LW-1:0]         len_last;
    logic [WAVE_DEPTH-1:0] raddr;
    logic                  adv;

    assign entry    = ctab[idx_q];
    assign e_off    = entry[WAVE_DEPTH-1:0];
    assign e_len    = entry[LEN_LSB +: LW];
    assign e_rep    = entry[REP_LSB +: REP_W];
    assign rep_last = (rep_q == '0) ? '0 : rep_q - REP_W'(1);
    assign len_last = len_q - LW'(1);
    assign raddr    = off_q + cnt_q[WAVE_DEPTH-1:0];

    // Busy covers the samples still in the read/output pipeline.
    assign busy_o  = (state_q != IDLE) | rd_v_q | val_q;
    assign valid_o = val_q;
    assign data_o  = data_q;

    always_ff @(posedge clk) begin
        if (ctrl_we_i) ctab[ctrl_addr_i] <= ctrl_data_i;
        if (wave_we_i) wram[wave_addr_i] <= wave_data_i;
        rdata_q <= wram[raddr];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        seq_d   = seq_q;
        inf_d   = inf_q;
        off_d   = off_q;
        len_d   = len_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        rd_v_d  = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kick_i && !busy_o) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    last_d  = last_i;
                    seq_d   = rep_i;
                    inf_d   = (rep_i == '0);
                end
            end
            LOAD: begin
                if (e_len == '0) begin
                    adv = 1'b1;
                end else begin
                    state_d = PLAY;
                    off_d   = e_off;
                    len_d   = e_len;
                    rep_d   = e_rep;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end
            end
            PLAY: begin
                rd_v_d = 1'b1;
                if (cnt_q == len_last) begin
                    cnt_d = '0;
                    if (rcnt_q == rep_last) adv = 1'b1;
                    else rcnt_d = rcnt_q + REP_W'(1);
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            state_d = LOAD;
            if (idx_q != last_q) begin
                idx_d = idx_q + CTRL_DEPTH'(1);
            end else begin
                idx_d = '0;
                if (!inf_q) seq_d = seq_q - REP_W'(1);
                if (!inf_q && seq_q == REP_W'(1)) state_d = IDLE;
            end
        end
        if (stop_i) begin
            state_d = IDLE;
            rd_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            seq_q   <= '0;
            inf_q   <= 1'b0;
            off_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rd_v_q  <= 1'b0;
            val_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            seq_q   <= seq_d;
            inf_q   <= inf_d;
            off_q   <= off_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            rd_v_q  <= rd_v_d;
            val_q   <= rd_v_q & ~stop_i;
            if (rd_v_q && !stop_i) data_q <= rdata_q;
        end
    end

endmodule

// File: rtl/mawg_multi_unit.sv
// Multi-channel arbitrary waveform generator: host write demux in front
// of NCH independent channels that can be kicked in lockstep.
module mawg_multi_unit
    import mawg_multi_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int CTRL_DEPTH = CTRL_DEPTH_DEF,
    parameter int WAVE_DEPTH = WAVE_DEPTH_DEF,
    parameter int WAVE_WIDTH = WAVE_WIDTH_DEF,
    parameter int REP_W      = REP_W_DEF,
    localparam int CHW       = ch_w(NCH),
    localparam int EW        = entry_w(REP_W, WAVE_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHW-1:0]            ctrl_ch,
    input  logic [CTRL_DEPTH-1:0]     ctrl_addr,
    input  logic [EW-1:0]             ctrl_data,
    input  logic                      ctrl_we,
    input  logic [CHW-1:0]            wave_ch,
    input  logic [WAVE_DEPTH-1:0]     wave_we_addr,
    input  logic [WAVE_WIDTH-1:0]     wave_we_data,
    input  logic                      wave_we,
    input  logic [NCH-1:0]            kick,
    input  logic [NCH-1:0]            force_stop,
    input  logic [NCH*REP_W-1:0]      repetition,
    input  logic [NCH*CTRL_DEPTH-1:0] ctrl_length,
    output logic [NCH-1:0]            busy,
    output logic [NCH-1:0]            wave_valid,
    output logic [NCH*WAVE_WIDTH-1:0] wave_out
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Channel numbers beyond NCH never match, so such writes drop.
        logic cwe, wwe;
        assign cwe = ctrl_we & (ctrl_ch == CHW'(g));
        assign wwe = wave_we & (wave_ch == CHW'(g));

        mawg_channel #(
            .CTRL_DEPTH (CTRL_DEPTH),
            .WAVE_DEPTH (WAVE_DEPTH),
            .WAVE_WIDTH (WAVE_WIDTH),
            .REP_W      (REP_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (reset_n),
            .ctrl_we_i   (cwe),
            .ctrl_addr_i (ctrl_addr),
            .ctrl_data_i (ctrl_data),
            .wave_we_i   (wwe),
            .wave_addr_i (wave_we_addr),
            .wave_data_i (wave_we_data),
            .kick_i      (kick[g]),
            .stop_i      (force_stop[g]),
            .rep_i       (repetition[g*REP_W +: REP_W]),
            .last_i      (ctrl_length[g*CTRL_DEPTH +: CTRL_DEPTH]),
            .busy_o      (busy[g]),
            .valid_o     (wave_valid[g]),
            .data_o      (wave_out[g*WAVE_WIDTH +: WAVE_WIDTH])
        );
    end

endmodule

// File: tb/tb_mawg_multi_unit.sv
// Randomised bench for mawg_multi_unit against a per-cycle sample
// schedule derived from the sequence tables.
module tb_mawg_multi_unit;

    localparam int NCH = 2;
    localparam int CD  = 2;
    localparam int WD  = 9;
    localparam int WW  = 16;
    localparam int RW  = 16;
    localparam int EW  = RW + 2 * WD + 1;
    localparam int H   = 400;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [0:0]        ctrl_ch = '0;
    logic [CD-1:0]     ctrl_addr = '0;
    logic [EW-1:0]     ctrl_data = '0;
    logic              ctrl_we = 1'b0;
    logic [0:0]        wave_ch = '0;
    logic [WD-1:0]     wave_we_addr = '0;
    logic [WW-1:0]     wave_we_data = '0;
    logic              wave_we = 1'b0;
    logic [NCH-1:0]    kick = '0;
    logic [NCH-1:0]    force_stop = '0;
    logic [NCH*RW-1:0] repetition = '0;
    logic [NCH*CD-1:0] ctrl_length = '0;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    wave_valid;
    logic [NCH*WW-1:0] wave_out;

    mawg_multi_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctrl_ch      (ctrl_ch),
        .ctrl_addr    (ctrl_addr),
        .ctrl_data    (ctrl_data),
        .ctrl_we      (ctrl_we),
        .wave_ch      (wave_ch),
        .wave_we_addr (wave_we_addr),
        .wave_we_data (wave_we_data),
        .wave_we      (wave_we),
        .kick         (kick),
        .force_stop   (force_stop),
        .repetition   (repetition),
        .ctrl_length  (ctrl_length),
        .busy         (busy),
        .wave_valid   (wave_valid),
        .wave_out     (wave_out)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] wmem [NCH][512];
    int            t_rep [NCH][4];
    int            t_len [NCH][4];
    int            t_off [NCH][4];

    bit            ev [NCH][H];
    logic [WW-1:0] ed [NCH][H];
    int            lastv [NCH];
    bit            inf [NCH];
    bit            mon [NCH];
    int            rel [NCH];
    logic [WW-1:0] hold [NCH];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Schedule: a LOAD costs one cycle, each PLAY cycle issues one read
    // whose sample appears two cycles later.
    task automatic build(input int ch, input int reps, input int last);
        int  p    = 0;
        int  lr   = -100;
        int  seqs = 0;
        bit  done = 0;
        for (int j = 0; j < H; j++) begin
            ev[ch][j] = 0;
            ed[ch][j] = '0;
        end
        inf[ch] = (reps == 0);
        while (!done && p < H) begin
            for (int e = 0; e <= last && p < H; e++) begin
                p++;
                if (t_len[ch][e] == 0) continue;
                for (int r = 0; r < ((t_rep[ch][e] == 0) ? 1 : t_rep[ch][e]); r++)
                    for (int k = 0; k < t_len[ch][e]; k++) begin
                        if (p + 2 < H) begin
                            ev[ch][p+2] = 1;
                            ed[ch][p+2] = wmem[ch][(t_off[ch][e] + k) % 512];
                        end
                        lr = p;
                        p++;
                    end
            end
            seqs++;
            if (reps != 0 && seqs == reps) done = 1;
        end
        lastv[ch] = (p - 1 > lr + 2) ? p - 1 : lr + 2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            bit ev_b, eb_b;
            int j;
            j = rel[ch];
            if (mon[ch]) begin
                rel[ch]++;
                j = rel[ch];
                ev_b = (j < H) ? ev[ch][j] : 1'b0;
                eb_b = inf[ch] ? 1'b1 : (j <= lastv[ch]);
                if (ev_b) hold[ch] = ed[ch][j];
            end else begin
                ev_b = 0;
                eb_b = 0;
            end
            chk($sformatf("ch%0d busy rel%0d", ch, j), busy[ch], eb_b);
            chk($sformatf("ch%0d valid rel%0d", ch, j), wave_valid[ch], ev_b);
            chk($sformatf("ch%0d data rel%0d", ch, j),
                wave_out[ch*WW +: WW], hold[ch]);
        end
    endtask

    task automatic wr_wave(input int ch, input logic [WD-1:0] a,
                           input logic [WW-1:0] d);
        wave_ch      = 1'(ch);
        wave_we_addr = a;
        wave_we_data = d;
        wave_we      = 1'b1;
        wmem[ch][a]  = d;
        tick();
        wave_we = 1'b0;
    endtask

    task automatic wr_ctrl(input int ch, input int e, input logic [RW-1:0] rep,
                           input logic [WD:0] len, input logic [WD-1:0] off);
        ctrl_ch   = 1'(ch);
        ctrl_addr = CD'(e);
        ctrl_data = {rep, len, off};
        ctrl_we   = 1'b1;
        t_rep[ch][e] = int'(rep);
        t_len[ch][e] = int'(len);
        t_off[ch][e] = int'(off);
        tick();
        ctrl_we = 1'b0;
    endtask

    task automatic setup(input int ch, input int reps, input int last);
        repetition[ch*RW +: RW]  = RW'(reps);
        ctrl_length[ch*CD +: CD] = CD'(last);
        build(ch, reps, last);
    endtask

    task automatic kick_go(input logic [NCH-1:0] m);
        kick = m;
        for (int c = 0; c < NCH; c++)
            if (m[c]) begin
                mon[c] = 1;
                rel[c] = -1;
            end
        tick();
        kick = '0;
    endtask

    task automatic run_done();
        int n = 0;
        for (int c = 0; c < NCH; c++)
            if (mon[c] && lastv[c] + 4 > n) n = lastv[c] + 4;
        repeat (n) tick();
        for (int c = 0; c < NCH; c++) mon[c] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            mon[c] = 0;
            rel[c] = 0;
            hold[c] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset valid", 32'(wave_valid), 32'h0);
        chk("reset data", wave_out, 32'h0);
        reset_n = 1'b1;

        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 512; a++)
                wr_wave(c, WD'(a), (c == 0) ? WW'(a) : WW'($urandom));

        // basic entry with repeat, ch1 untouched
        wr_ctrl(0, 0, 2, 4, 8);
        setup(0, 1, 0);
        kick_go(2'b01);
        run_done();

        // address wrap
        wr_ctrl(0, 0, 1, 4, 510);
        setup(0, 1, 0);
        kick_go(2'b01);
        run_done();

        // zero-length entry skipped
        wr_ctrl(0, 0, 1, 2, 0);
        wr_ctrl(0, 1, 1, 0, WD'($urandom));
        wr_ctrl(0, 2, 1, 3, 100);
        setup(0, 1, 2);
        kick_go(2'b01);
        run_done();

        // lockstep infinite, kick while busy, per-channel stop
        for (int e = 0; e < 4; e++) begin
            logic [RW-1:0] r;
            logic [WD:0]   l;
            logic [WD-1:0] o;
            r = RW'($urandom_range(0, 2));
            l = (WD+1)'($urandom_range(1, 5));
            o = WD'($urandom);
            wr_ctrl(0, e, r, l, o);
            wr_ctrl(1, e, r, l, o);
        end
        setup(0, 0, 3);
        setup(1, 0, 3);
        kick_go(2'b11);
        repeat (50) tick();
        kick = 2'b01;
        tick();
        kick = '0;
        repeat (49) tick();
        force_stop = 2'b10;
        mon[1] = 0;
        tick();
        force_stop = '0;
        repeat (20) tick();
        force_stop = 2'b01;
        mon[0] = 0;
        tick();
        force_stop = '0;
        repeat (3) tick();

        // kick and stop together
        setup(0, 1, 0);
        kick = 2'b01;
        force_stop = 2'b01;
        tick();
        kick = '0;
        force_stop = '0;
        repeat (5) tick();

        // random tables and kick masks
        repeat (4) begin
            logic [NCH-1:0] m;
            for (int c = 0; c < NCH; c++) begin
                for (int e = 0; e < 4; e++)
                    wr_ctrl(c, e, RW'($urandom_range(0, 3)),
                            (WD+1)'($urandom_range(0, 6)), WD'($urandom));
                repeat (3) wr_wave(c, WD'($urandom), WW'($urandom));
                setup(c, $urandom_range(1, 2), $urandom_range(0, 3));
            end
            m = NCH'($urandom_range(1, 3));
            kick_go(m);
            run_done();
        end

        // asynchronous reset mid-play
        wr_ctrl(0, 0, 1, 8, 0);
        setup(0, 1, 0);
        kick_go(2'b01);
        repeat (6) tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'h0);
        chk("async reset valid", 32'(wave_valid), 32'h0);
        chk("async reset data", wave_out, 32'h0);
        for (int c = 0; c < NCH; c++) begin
            mon[c] = 0;
            hold[c] = '0;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
